xpm_memory_sdpram: RTL and testbench

XPM_MEMORY_SDPRAM -- requirements
Module: xpm_memory_sdpram

---
 rtl/xpm_sdpram_pkg.sv | 69 ++++++
 rtl/sdpram_out_pipe.sv | 53 +++++
 rtl/xpm_memory_sdpram.sv | 141 ++++++++++++++
 tb/tb_xpm_memory_sdpram.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/xpm_sdpram_pkg.sv
// Shared constants and elaboration helpers for the simple dual-port RAM.
// Collision/X checks are compiled in only when SDPRAM_SIM_CHECK_EN is defined.
package xpm_sdpram_pkg;

  localparam int STR_BITS = 256;

  localparam logic [STR_BITS-1:0] MODE_COMMON_CLOCK = "common_clock";
  localparam logic [STR_BITS-1:0] MODE_NO_ECC = "no_ecc";

  typedef enum logic [1:0] {
    RD_LAT_1 = 2'd1,
    RD_LAT_2 = 2'd2
  } rd_lat_e;

  function automatic int calc_depth(
    input int mem_bits,
    input int word_bits
  );
    return mem_bits / word_bits;
  endfunction

  function automatic int calc_lanes(
    input int word_bits,
    input int lane_bits
  );
    return word_bits / lane_bits;
  endfunction

  function automatic int calc_idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lane_lsb(
    input int lane,
    input int lane_bits
  );
    return lane * lane_bits;
  endfunction

  // Left-padded hex string (e.g. "DEAD_BEEF") to a bit vector.
  function automatic logic [STR_BITS-1:0] hex_to_vec(
    input logic [STR_BITS-1:0] s
  );
    logic [STR_BITS-1:0] v;
    logic [7:0] c;
    logic [3:0] n;
    logic ok;
    v = '0;
    for (int i = STR_BITS/8 - 1; i >= 0; i--) begin
      c = s[i*8 +: 8];
      n = 4'h0;
      ok = 1'b1;
      if (c >= "0" && c <= "9") begin
        n = 4'(c - "0");
      end else if (c >= "a" && c <= "f") begin
        n = 4'(c - "a" + 8'd10);
      end else if (c >= "A" && c <= "F") begin
        n = 4'(c - "A" + 8'd10);
      end else begin
        ok = 1'b0;
      end
      if (ok) begin
        v = {v[STR_BITS-5:0], n};
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/sdpram_out_pipe.sv
// Port-B read pipeline: one or two register stages, reset only on the
// final stage so rstb never disturbs data still in flight.
module sdpram_out_pipe
  import xpm_sdpram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LATENCY = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             regce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] q1 = RST_VAL;

  if (LATENCY == int'(RD_LAT_2)) begin : g_lat2
    logic [WIDTH-1:0] q2 = RST_VAL;

    always_ff @(posedge clk) begin
      if (en) begin
        q1 <= din;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        q2 <= RST_VAL;
      end else if (regce) begin
        q2 <= q1;
      end
    end

    assign dout = q2;
  end else begin : g_lat1
    logic unused_regce;
    assign unused_regce = regce;

    always_ff @(posedge clk) begin
      if (rst) begin
        q1 <= RST_VAL;
      end else if (en) begin
        q1 <= din;
      end
    end

    assign dout = q1;
  end

endmodule

// File: rtl/xpm_memory_sdpram.sv
// Common-clock simple dual-port RAM with byte-lane writes and 1/2-cycle reads.
// Define SDPRAM_SIM_CHECK_EN to add simulation collision and X checks.
module xpm_memory_sdpram
  import xpm_sdpram_pkg::*;
#(
  parameter int ADDR_WIDTH_A = 15,
  parameter int ADDR_WIDTH_B = 15,
  parameter int MEMORY_SIZE = 1048576,
  parameter int WRITE_DATA_WIDTH_A = 32,
  parameter int READ_DATA_WIDTH_B = 32,
  parameter int BYTE_WRITE_WIDTH_A = 8,
  parameter int READ_LATENCY_B = 1,
  parameter logic [STR_BITS-1:0] READ_RESET_VALUE_B = "0",
  parameter logic [STR_BITS-1:0] MEMORY_INIT_PARAM = "0",
  parameter logic [STR_BITS-1:0] CLOCKING_MODE = "common_clock",
  parameter logic [STR_BITS-1:0] ECC_MODE = "no_ecc",
  parameter logic [STR_BITS-1:0] WRITE_MODE_B = "no_change",
  parameter logic [STR_BITS-1:0] MEMORY_PRIMITIVE = "auto",
  parameter logic [STR_BITS-1:0] MEMORY_INIT_FILE = "none",
  parameter logic [STR_BITS-1:0] WAKEUP_TIME = "disable_sleep",
  parameter logic [STR_BITS-1:0] MEMORY_OPTIMIZATION = "true",
  parameter logic [STR_BITS-1:0] RST_MODE_A = "SYNC",
  parameter logic [STR_BITS-1:0] RST_MODE_B = "SYNC",
  parameter int MESSAGE_CONTROL = 0,
  parameter int USE_MEM_INIT = 1,
  parameter int AUTO_SLEEP_TIME = 0,
  parameter int CASCADE_HEIGHT = 0,
  parameter int SIM_ASSERT_CHK = 0,
  parameter int USE_EMBEDDED_CONSTRAINT = 0,
  parameter int WRITE_PROTECT = 1
) (
  input  logic clka,
  input  logic clkb,
  input  logic rstb,
  input  logic ena,
  input  logic [WRITE_DATA_WIDTH_A/BYTE_WRITE_WIDTH_A-1:0] wea,
  input  logic [ADDR_WIDTH_A-1:0] addra,
  input  logic [WRITE_DATA_WIDTH_A-1:0] dina,
  input  logic enb,
  input  logic [ADDR_WIDTH_B-1:0] addrb,
  input  logic regceb,
  output logic [READ_DATA_WIDTH_B-1:0] doutb,
  input  logic sleep,
  input  logic injectsbiterra,
  input  logic injectdbiterra,
  output logic sbiterrb,
  output logic dbiterrb
);

  localparam int W = WRITE_DATA_WIDTH_A;
  localparam int BW = BYTE_WRITE_WIDTH_A;
  localparam int DEPTH = calc_depth(MEMORY_SIZE, W);
  localparam int NUM_LANES = calc_lanes(W, BW);
  localparam int IDX = calc_idx_bits(DEPTH);

  localparam logic [W-1:0] INIT_WORD = W'(hex_to_vec(MEMORY_INIT_PARAM));
  localparam logic [W-1:0] RST_WORD = W'(hex_to_vec(READ_RESET_VALUE_B));

  localparam bit unused_cfg = ^{
    WRITE_MODE_B, MEMORY_PRIMITIVE, MEMORY_INIT_FILE,
    WAKEUP_TIME, MEMORY_OPTIMIZATION, RST_MODE_A, RST_MODE_B,
    MESSAGE_CONTROL, USE_MEM_INIT, AUTO_SLEEP_TIME,
    CASCADE_HEIGHT, SIM_ASSERT_CHK, USE_EMBEDDED_CONSTRAINT,
    WRITE_PROTECT
  };

  if (READ_DATA_WIDTH_B != WRITE_DATA_WIDTH_A) begin : g_err_width
    $error("read and write widths must match");
  end
  if (READ_LATENCY_B != 1 && READ_LATENCY_B != 2) begin : g_err_lat
    $error("READ_LATENCY_B must be 1 or 2");
  end
  if (CLOCKING_MODE != MODE_COMMON_CLOCK) begin : g_err_clk
    $error("only common_clock is supported");
  end
  if (ECC_MODE != MODE_NO_ECC) begin : g_err_ecc
    $error("only no_ecc is supported");
  end
  if (W % BW != 0) begin : g_err_lane
    $error("data width must be a multiple of the lane width");
  end

  logic unused_inputs;
  assign unused_inputs = ^{clkb, injectsbiterra, injectdbiterra};

  logic [W-1:0] mem [DEPTH] = '{default: INIT_WORD};

  // Upper address bits beyond the array depth are dropped (wrap).
  logic [IDX-1:0] wr_idx;
  logic [IDX-1:0] rd_idx;
  logic wr_go;
  logic rd_go;
  logic [W-1:0] rd_word;

  assign wr_idx = IDX'(addra);
  assign rd_idx = IDX'(addrb);
  assign wr_go = ena & ~sleep;
  assign rd_go = enb & ~sleep;

  always_ff @(posedge clka) begin
    if (wr_go) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wea[i]) begin
          mem[wr_idx][lane_lsb(i, BW) +: BW] <= dina[lane_lsb(i, BW) +: BW];
        end
      end
    end
  end

  // Array read sees pre-edge contents, giving read-first collisions.
  assign rd_word = mem[rd_idx];

  sdpram_out_pipe #(
    .WIDTH  (W),
    .LATENCY(READ_LATENCY_B),
    .RST_VAL(RST_WORD)
  ) u_out_pipe (
    .clk  (clka),
    .rst  (rstb),
    .en   (rd_go),
    .regce(regceb & ~sleep),
    .din  (rd_word),
    .dout (doutb)
  );

  assign sbiterrb = 1'b0;
  assign dbiterrb = 1'b0;

`ifdef SDPRAM_SIM_CHECK_EN
  always @(posedge clka) begin
    if ($isunknown({ena, enb, wea})) begin
      $display("%m: X on ena/enb/wea at %0t", $time);
    end
    if (wr_go && (|wea) && rd_go && wr_idx == rd_idx) begin
      $display("%m: read/write collision at index %0h, %0t",
               wr_idx, $time);
    end
  end
`endif

endmodule

// File: tb/tb_xpm_memory_sdpram.sv
// Directed bench for xpm_memory_sdpram at default parameters (latency 1).
// Expected values are hand-computed constants.
module tb_xpm_memory_sdpram;

  logic clka = 1'b0;
  logic clkb = 1'b0;
  logic rstb;
  logic ena;
  logic [3:0] wea;
  logic [14:0] addra;
  logic [31:0] dina;
  logic enb;
  logic [14:0] addrb;
  logic regceb;
  logic [31:0] doutb;
  logic sleep;
  logic injectsbiterra;
  logic injectdbiterra;
  logic sbiterrb;
  logic dbiterrb;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clka = ~clka;

  xpm_memory_sdpram dut (
    .clka          (clka),
    .clkb          (clkb),
    .rstb          (rstb),
    .ena           (ena),
    .wea           (wea),
    .addra         (addra),
    .dina          (dina),
    .enb           (enb),
    .addrb         (addrb),
    .regceb        (regceb),
    .doutb         (doutb),
    .sleep         (sleep),
    .injectsbiterra(injectsbiterra),
    .injectdbiterra(injectdbiterra),
    .sbiterrb      (sbiterrb),
    .dbiterrb      (dbiterrb)
  );

  task automatic check(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  initial begin
    rstb = 1'b0;
    ena = 1'b0;
    wea = 4'h0;
    addra = '0;
    dina = '0;
    enb = 1'b0;
    addrb = '0;
    regceb = 1'b1;
    sleep = 1'b0;
    injectsbiterra = 1'b1;
    injectdbiterra = 1'b1;
    #1;
    check("init_dout", doutb, 32'h0);
    check("ecc_flags", {30'h0, sbiterrb, dbiterrb}, 32'h0);

    // unwritten word reads the init value
    enb = 1'b1; addrb = 15'h0123;
    tick();
    check("init_mem", doutb, 32'h0);

    // full write then read
    enb = 1'b0;
    ena = 1'b1; wea = 4'hF; addra = 15'h0010; dina = 32'hDEADBEEF;
    tick();
    ena = 1'b0; wea = 4'h0;
    enb = 1'b1; addrb = 15'h0010;
    tick();
    check("full_wr", doutb, 32'hDEADBEEF);

    // single lane
    enb = 1'b0;
    ena = 1'b1; wea = 4'b0010; dina = 32'h00005500;
    tick();
    ena = 1'b0; wea = 4'h0; enb = 1'b1;
    tick();
    check("byte_wr", doutb, 32'hDEAD55EF);

    // write protect
    enb = 1'b0;
    ena = 1'b0; wea = 4'hF; dina = 32'h12345678;
    tick();
    wea = 4'h0; enb = 1'b1;
    tick();
    check("wr_protect", doutb, 32'hDEAD55EF);

    // same-address collision returns old data
    ena = 1'b1; wea = 4'hF; dina = 32'hCAFEF00D;
    tick();
    check("collide_old", doutb, 32'hDEAD55EF);
    ena = 1'b0; wea = 4'h0;
    tick();
    check("collide_new", doutb, 32'hCAFEF00D);

    // reset beats enb; concurrent write still lands
    rstb = 1'b1;
    ena = 1'b1; wea = 4'hF; addra = 15'h0020; dina = 32'h11223344;
    tick();
    check("rst_dout", doutb, 32'h0);
    rstb = 1'b0; ena = 1'b0; wea = 4'h0;
    tick();
    check("rst_mem_kept", doutb, 32'hCAFEF00D);
    addrb = 15'h0020;
    tick();
    check("rst_wr_done", doutb, 32'h11223344);

    // top address and hold
    enb = 1'b0;
    ena = 1'b1; wea = 4'hF; addra = 15'h7FFF; dina = 32'hA5A5A5A5;
    tick();
    ena = 1'b0; wea = 4'h0;
    enb = 1'b1; addrb = 15'h7FFF;
    tick();
    check("top_addr", doutb, 32'hA5A5A5A5);
    enb = 1'b0; addrb = 15'h0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_%0d", i), doutb, 32'hA5A5A5A5);
    end

    // sleep blocks both ports
    sleep = 1'b1;
    ena = 1'b1; wea = 4'hF; addra = 15'h7FFF; dina = 32'h0;
    enb = 1'b1; addrb = 15'h0010;
    tick();
    check("sleep_rd", doutb, 32'hA5A5A5A5);
    sleep = 1'b0; ena = 1'b0; wea = 4'h0;
    addrb = 15'h7FFF;
    tick();
    check("sleep_wr", doutb, 32'hA5A5A5A5);
    addrb = 15'h0010;
    tick();
    check("final_rd", doutb, 32'hCAFEF00D);
    check("ecc_end", {30'h0, sbiterrb, dbiterrb}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
